// File: rtl/ahfp_sub_arbiter.sv
// Round-robin arbiter that shares one fixed-latency FP subtractor among NUM_REQ clients.
// A tag pipeline matched to LATENCY steers each result back to its issuer as a one-cycle strobe.
module ahfp_sub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 7,
  parameter int CNT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    hold,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_dataa,
  input  logic [32*NUM_REQ-1:0]   req_datab,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             sub_dataa,
  output logic [31:0]             sub_datab,
  input  logic [31:0]             sub_result,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_result,
  output logic [CNT_W-1:0]        in_flight,
  output logic                    idle
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     winner;
  logic               found;
  logic               grant;
  logic               retire;
  logic [31:0]        last_a;
  logic [31:0]        last_b;
  logic [LATENCY-1:0] tag_vld;
  logic [IDW-1:0]     tag_id [LATENCY];

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  assign grant = found && !hold && reset_n;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[winner] = 1'b1;
  end

  // Idle cycles replay the last operands so the subtractor inputs stay quiet.
  assign sub_dataa = grant ? req_dataa[32*winner +: 32] : last_a;
  assign sub_datab = grant ? req_datab[32*winner +: 32] : last_b;

  assign retire     = tag_vld[LATENCY-1];
  assign rsp_result = sub_result;

  always_comb begin
    rsp_valid = '0;
    if (retire) rsp_valid[tag_id[LATENCY-1]] = 1'b1;
  end

  assign idle = (in_flight == '0) && !grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr    <= '0;
      last_a    <= '0;
      last_b    <= '0;
      tag_vld   <= '0;
      in_flight <= '0;
    end else begin
      if (grant) begin
        rr_ptr <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        last_a <= sub_dataa;
        last_b <= sub_datab;
      end
      tag_vld <= {tag_vld[LATENCY-2:0], grant};
      case ({grant, retire})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  // IDs are only consulted alongside their valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    tag_id[0] <= winner;
    for (int k = 1; k < LATENCY; k++) tag_id[k] <= tag_id[k-1];
  end

  always @(posedge clk) begin
    if (reset_n) begin
      assert (in_flight <= CNT_W'(LATENCY));
      assert (!(grant && !retire && in_flight == CNT_W'(LATENCY)));
      assert (!(retire && !grant && in_flight == '0));
    end
  end

endmodule
